game_link_tx: RTL and testbench
===============================

# game_link_tx

Frame transmitter for the inter-board game link. It turns local game events into 4-byte frames and hands them byte-by-byte to the UART transmitter over a valid/ready handshake: the local Enter press, end of the local turn, and local HP changes. The remote board's link receiver decodes these frames into its `enter_pressed_remote`, turn-done and `hp_remote` inputs. The block sits between the local game control logic and the UART TX.

## Interface
- `HEARTBEAT_CYCLES`, default 6_500_000. Idle cycles before an unsolicited HP frame is resent (100 ms at 65 MHz). Must be ≥ 2.
- `clk` input 1. System clock.
- `rst` input 1. Reset: one clock; asynchronous, active-high.
- `tx_en` input 1. Link enable. When low, no new frame starts; a frame in progress completes.
- `enter_pressed_local` input 1. Single-cycle pulse: local Enter press.
- `turn_done_local` input 1. Single-cycle pulse: local player finished the turn.
- `hp_local` input 10. Current local HP.
- `tx_ready` input 1. UART TX can accept a byte.
- `tx_data` output 8. Byte offered to UART TX.
- `tx_valid` output 1. `tx_data` is valid.
- `busy` output 1. High while in any SEND_* state.
- `frame_sent` output 1. One-cycle pulse when the last byte of a frame is accepted.

## Operation
- Frame layout, 4 bytes, sent in order:
  - HDR = {4'hA, type[3:0]}
  - HI = {6'b0, payload[9:8]}
  - LO = payload[7:0]
  - CHK = HDR ^ HI ^ LO
- Frame types:
  - 4'h1 ENTER, payload 0.
  - 4'h2 TURN_DONE, payload 0.
  - 4'h3 HP, payload = HP snapshot.
- Pending sources:
  - `pend_enter` is set by `enter_pressed_local`.
  - `pend_turn` is set by `turn_done_local`.
  - HP is pending while `hp_local != hp_sent`, or when the heartbeat expires.
  - Repeated pulses while pending coalesce into one frame.
- Priority when several sources are pending: ENTER > TURN_DONE > HP.
- FSM states: IDLE, SEND_HDR, SEND_HI, SEND_LO, SEND_CHK.
- IDLE → SEND_HDR when `tx_en` is high and any source is pending, counting pulses present in the same cycle. On this transition:
  - Latch type and payload into frame registers.
  - Clear the selected pending flag. A pulse for that same source arriving in that cycle is absorbed.
  - For HP frames, set `hp_sent` ← `hp_local` and use that same value as the payload.
- SEND_x → next state on the cycle with `tx_valid && tx_ready`. SEND_CHK → IDLE with `frame_sent` = 1 for that one cycle.
- `tx_data` and `tx_valid` are registered. While `tx_valid` is high and `tx_ready` is low, `tx_data` holds stable; `tx_valid` never drops mid-frame.
- Heartbeat counter:
  - Increments in IDLE while `tx_en` is high and nothing is pending.
  - Reaching HEARTBEAT_CYCLES-1 forces an HP frame (payload = current `hp_local`).
  - Clears whenever any frame starts, and whenever `tx_en` is low.
- Event pulses while busy or while `tx_en` is low are latched, not lost.
- HP changes during a frame are compared against `hp_sent`. A change that returns to the old value before the next IDLE sends nothing (except via heartbeat).

## Timing
- Reset values:
  - State IDLE.
  - `tx_valid` 0, `tx_data` 8'h00, `busy` 0, `frame_sent` 0.
  - Pending flags 0, `hp_sent` 10'd0, heartbeat counter 0.
- Async reset mid-frame: outputs go to reset values immediately and the partial frame is abandoned. The receiver resyncs on the next 4'hA header.
- Start latency: in IDLE with `tx_en` high, a pulse in cycle N gives `tx_valid` = 1 with HDR in cycle N+1.
- Throughput: with `tx_ready` held high, bytes are accepted in N+1..N+4 and `frame_sent` pulses in N+4.
- Back-to-back frames: if the last byte is accepted in cycle M, state is IDLE in M+1 and the next HDR is offered in M+2. There is a one-cycle gap.
- After reset with `hp_local` ≠ 0, an HP frame starts on the first cycle `tx_en` is high.

## Test plan
- Enter pulse, `tx_ready` = 1, `hp_local` = 0: bytes A1, 00, 00, A1 on 4 consecutive cycles starting the cycle after the pulse; `frame_sent` pulses on the 4th byte.
- `hp_local` 0 → 10'h2C5, `tx_ready` = 1: frame A3, 02, C5, 64; `hp_sent` = 10'h2C5; no further frame until HP changes or the heartbeat expires.
- Enter and turn_done pulses in the same cycle: A1 00 00 A1, one idle cycle, then A2 00 00 A2. Three Enter pulses during a frame still yield exactly one extra ENTER frame.
- Backpressure: `tx_ready` toggled pseudo-randomly: byte order is preserved; `tx_data` stays stable while valid is high and ready is low; no byte is duplicated or skipped.
- HEARTBEAT_CYCLES = 8, idle, `hp_local` = 10'd100: an HP frame A3 00 64 C7 repeats every 8 idle cycles plus frame time. Holding `tx_en` low suppresses it, and Enter pulses stay pending until `tx_en` rises.
- Assert `rst` after the HI byte: `tx_valid` goes low asynchronously. After release with `hp_local` = 5, the first frame is A3 00 05 A6.

Source files
------------

// File: rtl/game_link_tx.sv
// game_link_tx
// Turns local game events (Enter press, turn done, HP change / heartbeat)
// into 4-byte link frames {HDR, HI, LO, CHK} and offers them byte-by-byte
// to the UART transmitter over a valid/ready handshake.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   tx_en                  link enable; gates only the start of a new frame
//   enter_pressed_local    1-cycle pulse, local Enter press
//   turn_done_local        1-cycle pulse, local turn finished
//   hp_local[9:0]          current local HP
//   tx_ready               UART TX accepts tx_data this cycle
//   tx_data[7:0]           registered byte offered to UART TX
//   tx_valid               registered, tx_data is valid
//   busy                   high in any SEND_* state
//   frame_sent             1-cycle pulse as the CHK byte is accepted
module game_link_tx #(
   parameter int HEARTBEAT_CYCLES = 6_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       enter_pressed_local,
   input  logic       turn_done_local,
   input  logic [9:0] hp_local,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       busy,
   output logic       frame_sent
);

   localparam int HB_W = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

   localparam logic [3:0] T_ENTER = 4'h1;
   localparam logic [3:0] T_TURN  = 4'h2;
   localparam logic [3:0] T_HP    = 4'h3;

   typedef enum logic [2:0] {
      IDLE,
      SEND_HDR,
      SEND_HI,
      SEND_LO,
      SEND_CHK
   } state_t;

   state_t          state, state_n;
   logic [7:0]      tx_data_n;
   logic            tx_valid_n;
   logic            pend_enter, pend_enter_n;
   logic            pend_turn, pend_turn_n;
   logic [9:0]      hp_sent, hp_sent_n;
   logic [HB_W-1:0] hb_cnt, hb_cnt_n;
   logic [3:0]      frm_type, frm_type_n;
   logic [9:0]      frm_pay, frm_pay_n;

   // Requests include pulses arriving this very cycle so a pulse in IDLE
   // starts its frame on the next edge.
   logic enter_req, turn_req, hp_req, any_req;
   logic [7:0] b_hi, b_lo, b_chk;

   assign enter_req = pend_enter | enter_pressed_local;
   assign turn_req  = pend_turn | turn_done_local;
   assign hp_req    = (hp_local != hp_sent) || (hb_cnt == HB_LAST);
   assign any_req   = enter_req | turn_req | hp_req;

   assign b_hi  = {6'b0, frm_pay[9:8]};
   assign b_lo  = frm_pay[7:0];
   assign b_chk = {4'hA, frm_type} ^ b_hi ^ b_lo;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         tx_data    <= 8'h00;
         tx_valid   <= 1'b0;
         pend_enter <= 1'b0;
         pend_turn  <= 1'b0;
         hp_sent    <= 10'd0;
         hb_cnt     <= '0;
         frm_type   <= 4'h0;
         frm_pay    <= 10'd0;
      end else begin
         state      <= state_n;
         tx_data    <= tx_data_n;
         tx_valid   <= tx_valid_n;
         pend_enter <= pend_enter_n;
         pend_turn  <= pend_turn_n;
         hp_sent    <= hp_sent_n;
         hb_cnt     <= hb_cnt_n;
         frm_type   <= frm_type_n;
         frm_pay    <= frm_pay_n;
      end
   end

   always_comb begin
      state_n      = state;
      tx_data_n    = tx_data;
      tx_valid_n   = tx_valid;
      pend_enter_n = enter_req;   // pulses are latched in every state
      pend_turn_n  = turn_req;
      hp_sent_n    = hp_sent;
      hb_cnt_n     = hb_cnt;
      frm_type_n   = frm_type;
      frm_pay_n    = frm_pay;
      frame_sent   = 1'b0;

      case (state)
         IDLE: begin
            if (!tx_en) begin
               hb_cnt_n = '0;
            end else if (any_req) begin
               // Clearing the selected flag also swallows a same-cycle pulse.
               if (enter_req) begin
                  frm_type_n   = T_ENTER;
                  frm_pay_n    = 10'd0;
                  pend_enter_n = 1'b0;
               end else if (turn_req) begin
                  frm_type_n  = T_TURN;
                  frm_pay_n   = 10'd0;
                  pend_turn_n = 1'b0;
               end else begin
                  frm_type_n = T_HP;
                  frm_pay_n  = hp_local;
                  hp_sent_n  = hp_local;
               end
               tx_data_n  = {4'hA, frm_type_n};
               tx_valid_n = 1'b1;
               hb_cnt_n   = '0;
               state_n    = SEND_HDR;
            end else begin
               hb_cnt_n = hb_cnt + HB_W'(1);
            end
         end
         SEND_HDR: if (tx_valid && tx_ready) begin
            tx_data_n = b_hi;
            state_n   = SEND_HI;
         end
         SEND_HI: if (tx_valid && tx_ready) begin
            tx_data_n = b_lo;
            state_n   = SEND_LO;
         end
         SEND_LO: if (tx_valid && tx_ready) begin
            tx_data_n = b_chk;
            state_n   = SEND_CHK;
         end
         SEND_CHK: if (tx_valid && tx_ready) begin
            tx_valid_n = 1'b0;
            frame_sent = 1'b1;
            state_n    = IDLE;
         end
         default: begin
            state_n    = IDLE;
            tx_valid_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_game_link_tx.sv
// Directed bench for game_link_tx with a short heartbeat (8 cycles).
module tb_game_link_tx;

   localparam int HB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_en;
   logic       enter_pressed_local;
   logic       turn_done_local;
   logic [9:0] hp_local;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       busy;
   logic       frame_sent;

   game_link_tx #(.HEARTBEAT_CYCLES(HB)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .tx_en               (tx_en),
      .enter_pressed_local (enter_pressed_local),
      .turn_done_local     (turn_done_local),
      .hp_local            (hp_local),
      .tx_ready            (tx_ready),
      .tx_data             (tx_data),
      .tx_valid            (tx_valid),
      .busy                (busy),
      .frame_sent          (frame_sent)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Byte monitor, frame counter and hold-under-backpressure watcher.
   logic [7:0] acc_q[$];
   int         fs_cnt   = 0;
   int         stab_err = 0;
   logic       pv = 1'b0, pr = 1'b1;
   logic [7:0] pd = 8'h00;

   always @(posedge clk) begin
      if (!rst) begin
         if (tx_valid && tx_ready) acc_q.push_back(tx_data);
         if (frame_sent) fs_cnt++;
         if (pv && !pr && (!tx_valid || tx_data != pd)) stab_err++;
      end
      pv <= tx_valid;
      pr <= tx_ready;
      pd <= tx_data;
   end

   // Expects HDR visible now; walks the 4 bytes with tx_ready high.
   // pe pulses Enter during the first three bytes.
   task automatic exp_frame(input string tag, input logic [31:0] w, input logic pe);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_data"}, {24'd0, tx_data}, {24'd0, w[31-8*i -: 8]});
         check({tag, "_fsent"}, {31'd0, frame_sent}, {31'd0, i == 3});
         enter_pressed_local = pe && (i < 3);
         step();
      end
      enter_pressed_local = 1'b0;
   endtask

   task automatic exp_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, {31'd0, tx_valid}, 32'd0);
         step();
      end
   endtask

   logic [7:0] bp_exp [8];

   initial begin
      rst = 1'b1; tx_en = 1'b0; enter_pressed_local = 1'b0;
      turn_done_local = 1'b0; hp_local = 10'd0; tx_ready = 1'b1;
      step(); step();
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_data", {24'd0, tx_data}, 32'h00);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fsent", {31'd0, frame_sent}, 32'd0);
      rst = 1'b0;
      step();

      // Enter frame, HDR the cycle after the pulse.
      tx_en = 1'b1; enter_pressed_local = 1'b1;
      step();
      enter_pressed_local = 1'b0;
      exp_frame("enter", 32'hA10000A1, 1'b0);
      check("enter_done_busy", {31'd0, busy}, 32'd0);
      tx_en = 1'b0; step();

      // HP change, then silence while HP is unchanged.
      hp_local = 10'h2C5; tx_en = 1'b1;
      step();
      exp_frame("hp", 32'hA302C564, 1'b0);
      exp_idle("hp_quiet", 5);
      tx_en = 1'b0; step();

      // Simultaneous Enter + turn_done: priority and one-cycle gap.
      tx_en = 1'b1; enter_pressed_local = 1'b1; turn_done_local = 1'b1;
      step();
      enter_pressed_local = 1'b0; turn_done_local = 1'b0;
      exp_frame("both_e", 32'hA10000A1, 1'b0);
      check("both_gap", {31'd0, tx_valid}, 32'd0);
      step();
      exp_frame("both_t", 32'hA20000A2, 1'b0);
      tx_en = 1'b0; step();

      // Repeated Enter pulses during a frame coalesce into one frame.
      tx_en = 1'b1; enter_pressed_local = 1'b1;
      step();
      enter_pressed_local = 1'b0;
      exp_frame("coal_1", 32'hA10000A1, 1'b1);
      check("coal_gap", {31'd0, tx_valid}, 32'd0);
      step();
      exp_frame("coal_2", 32'hA10000A1, 1'b0);
      exp_idle("coal_once", 3);
      tx_en = 1'b0; step();

      // Backpressure: turn frame then HP frame, random tx_ready.
      acc_q.delete();
      bp_exp = '{8'hA2, 8'h00, 8'h00, 8'hA2, 8'hA3, 8'h03, 8'hFF, 8'h5F};
      begin
         int fs0;
         fs0 = fs_cnt;
         hp_local = 10'h3FF; tx_en = 1'b1; turn_done_local = 1'b1;
         step();
         turn_done_local = 1'b0;
         for (int c = 0; c < 300 && fs_cnt < fs0 + 2; c++) begin
            tx_ready = 1'($urandom_range(0, 1));
            step();
         end
         tx_ready = 1'b1; tx_en = 1'b0;
         check("bp_frames", fs_cnt - fs0, 32'd2);
      end
      check("bp_count", acc_q.size(), 32'd8);
      for (int i = 0; i < 8; i++)
         check($sformatf("bp_byte%0d", i), {24'd0, (i < acc_q.size()) ? acc_q[i] : 8'hXX},
               {24'd0, bp_exp[i]});
      check("bp_stable", stab_err, 32'd0);
      step();

      // Heartbeat: first frame from HP change, then resend after 8 idle cycles.
      hp_local = 10'd100; tx_en = 1'b1;
      step();
      exp_frame("hb_1", 32'hA30064C7, 1'b0);
      exp_idle("hb_wait", 8);
      exp_frame("hb_2", 32'hA30064C7, 1'b0);

      // tx_en low: heartbeat suppressed, Enter stays pending.
      tx_en = 1'b0;
      enter_pressed_local = 1'b1; step(); enter_pressed_local = 1'b0;
      exp_idle("en_low", 12);
      tx_en = 1'b1;
      step();
      exp_frame("en_rise", 32'hA10000A1, 1'b0);

      // Async reset after the HI byte.
      enter_pressed_local = 1'b1;
      step();
      enter_pressed_local = 1'b0;
      check("pre_rst_hdr", {24'd0, tx_data}, 32'hA1);
      step();
      check("pre_rst_hi", {24'd0, tx_data}, 32'h00);
      step();
      hp_local = 10'd5;
      rst = 1'b1;
      #2;
      check("arst_valid", {31'd0, tx_valid}, 32'd0);
      check("arst_data", {24'd0, tx_data}, 32'h00);
      check("arst_busy", {31'd0, busy}, 32'd0);
      step();
      rst = 1'b0;
      step();
      exp_frame("post_rst", 32'hA30005A6, 1'b0);
      tx_en = 1'b0; step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
